// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table response checker.
// Holds the run-state encoding, vector-count derivation and settle-timer width.
package tt_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } tt_state_e;

   localparam int SETTLE_CNT_W = 4;

   function automatic int num_vec(input int num_in);
      return 1 << num_in;
   endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that paces the settle interval between driving a vector and sampling it.
// expire is high whenever the count has reached zero.
module settle_timer
   import tt_check_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [SETTLE_CNT_W-1:0] len,
   output logic                    expire
);

   logic [SETTLE_CNT_W-1:0] cnt_q;
   logic [SETTLE_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = len;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive-stimulus response checker: walks every input vector, samples f_in, builds the
// observed table and counts mismatches. Optional macro TT_CHECK_FIRST_ERR_EN adds first-error capture.
//
// state     | meaning
// ST_IDLE   | waiting for start; results of last run held
// ST_SETTLE | vector driven, waiting SETTLE cycles for the DUT to settle
// ST_SAMPLE | sample f_in into tt and compare with latched expected
// ST_DONE   | one-cycle done pulse, pass valid
module truth_table_checker
   import tt_check_pkg::*;
#(
   parameter  int NUM_IN  = 3,
   parameter  int SETTLE  = 2,
   localparam int NUM_VEC = num_vec(NUM_IN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NUM_VEC-1:0] expected,
   input  logic               f_in,
   output logic [NUM_IN-1:0]  vec,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [NUM_VEC-1:0] tt,
   output logic [NUM_IN:0]    err_cnt
`ifdef TT_CHECK_FIRST_ERR_EN
   ,
   output logic [NUM_IN-1:0]  first_err_idx,
   output logic               first_err_vld
`endif
);

   if (NUM_IN < 1 || NUM_IN > 6) begin : g_bad_num_in
      $error("truth_table_checker: NUM_IN out of range 1..6");
   end
   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("truth_table_checker: SETTLE out of range 1..15");
   end

   localparam logic [NUM_IN-1:0]       VEC_LAST   = '1;
   localparam logic [NUM_IN:0]         ERR_ONE    = {{NUM_IN{1'b0}}, 1'b1};
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LEN = SETTLE_CNT_W'(SETTLE - 1);

   tt_state_e          state_q,   state_d;
   logic [NUM_IN-1:0]  vec_q,     vec_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;
   logic               pass_q,    pass_d;
   logic [NUM_VEC-1:0] tt_q,      tt_d;
   logic [NUM_IN:0]    err_cnt_q, err_cnt_d;
   logic [NUM_VEC-1:0] exp_q,     exp_d;
`ifdef TT_CHECK_FIRST_ERR_EN
   logic [NUM_IN-1:0]  fe_idx_q,  fe_idx_d;
   logic               fe_vld_q,  fe_vld_d;
`endif

   logic timer_load;
   logic timer_expire;
   logic mismatch;

   settle_timer u_settle_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .len    (SETTLE_LEN),
      .expire (timer_expire)
   );

   // Compare against the copy latched at start so later changes on expected cannot disturb the run.
   assign mismatch = (f_in != exp_q[vec_q]);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      tt_d       = tt_q;
      err_cnt_d  = err_cnt_q;
      exp_d      = exp_q;
      timer_load = 1'b0;
`ifdef TT_CHECK_FIRST_ERR_EN
      fe_idx_d   = fe_idx_q;
      fe_vld_d   = fe_vld_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SETTLE;
               exp_d      = expected;
               tt_d       = '0;
               err_cnt_d  = '0;
               pass_d     = 1'b0;
               vec_d      = '0;
               busy_d     = 1'b1;
               timer_load = 1'b1;
`ifdef TT_CHECK_FIRST_ERR_EN
               fe_idx_d   = '0;
               fe_vld_d   = 1'b0;
`endif
            end
         end
         ST_SETTLE: begin
            if (timer_expire) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            tt_d[vec_q] = f_in;
            if (mismatch) begin
               err_cnt_d = err_cnt_q + ERR_ONE;
`ifdef TT_CHECK_FIRST_ERR_EN
               if (!fe_vld_q) begin
                  fe_idx_d = vec_q;
                  fe_vld_d = 1'b1;
               end
`endif
            end
            if (vec_q == VEC_LAST) begin
               // done and pass are registered here so both are visible in the DONE cycle.
               state_d = ST_DONE;
               vec_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_cnt_d == '0);
            end else begin
               state_d    = ST_SETTLE;
               vec_d      = vec_q + 1'b1;
               timer_load = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vec_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         tt_q      <= '0;
         err_cnt_q <= '0;
         exp_q     <= '0;
`ifdef TT_CHECK_FIRST_ERR_EN
         fe_idx_q  <= '0;
         fe_vld_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         tt_q      <= tt_d;
         err_cnt_q <= err_cnt_d;
         exp_q     <= exp_d;
`ifdef TT_CHECK_FIRST_ERR_EN
         fe_idx_q  <= fe_idx_d;
         fe_vld_q  <= fe_vld_d;
`endif
      end
   end

   assign vec     = vec_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign tt      = tt_q;
   assign err_cnt = err_cnt_q;
`ifdef TT_CHECK_FIRST_ERR_EN
   assign first_err_idx = fe_idx_q;
   assign first_err_vld = fe_vld_q;
`endif

endmodule
